// File: rtl/scope_pkg.sv
// Shared types and constants for the triggered sample capture path.
package scope_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int DEPTH_DEF  = 640;

    localparam logic [11:0] ADC_FULL_SCALE = 12'hFFF;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/waveform_capture.sv
// Triggered single-shot capture buffer between ADC and VGA renderer.
// Define AUTO_TRIGGER_EN to build the ARMED-state timeout forced trigger.
module waveform_capture
    import scope_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int ADDR_W       = 10,
    parameter int DECIM        = 1,
    parameter int AUTO_TIMEOUT = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trigger_level,
    input  logic              rearm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              capture_done,
    output logic              auto_trig,
    output logic [1:0]        state_dbg
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        decim_q, decim_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              done_q, done_d;
    logic              rd_ok_q;
    logic              accept;
    logic              level_trig;
    logic              force_trig;
    logic              trig_fire;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] ram_rdata;

    assign accept     = sample_valid && (decim_q == 8'(DECIM - 1));
    assign level_trig = prev_valid_q && (prev_q < trigger_level)
                        && (sample_data >= trigger_level);

`ifdef AUTO_TRIGGER_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_q;
    logic            auto_q;

    assign force_trig = (to_q == TO_W'(AUTO_TIMEOUT));
    assign auto_trig  = auto_q;

    // Saturates at the timeout; any exit from ARMED restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_q   <= '0;
            auto_q <= 1'b0;
        end else begin
            if (state_q != ARMED) begin
                to_q <= '0;
            end else if (!force_trig) begin
                to_q <= to_q + 1'b1;
            end
            if (trig_fire) begin
                auto_q <= !level_trig;
            end
        end
    end
`else
    assign force_trig = 1'b0;
    assign auto_trig  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        done_d       = done_q;
        decim_d      = decim_q;
        we           = 1'b0;
        waddr        = wr_addr_q;
        trig_fire    = 1'b0;
        if (sample_valid) begin
            decim_d = accept ? 8'd0 : decim_q + 8'd1;
        end
        case (state_q)
            ARMED: begin
                if (accept && (level_trig || force_trig)) begin
                    trig_fire = 1'b1;
                    we        = 1'b1;
                    waddr     = '0;
                    wr_addr_d = ADDR_W'(1);
                    state_d   = CAPTURE;
                end else if (accept) begin
                    prev_d       = sample_data;
                    prev_valid_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (rearm) begin
                    state_d      = ARMED;
                    done_d       = 1'b0;
                    prev_valid_d = 1'b0;
                    wr_addr_d    = '0;
                    decim_d      = 8'd0;
                end
            end
            default: begin
                state_d      = ARMED;
                done_d       = 1'b0;
                prev_valid_d = 1'b0;
                wr_addr_d    = '0;
                decim_d      = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ARMED;
            wr_addr_q    <= '0;
            decim_q      <= 8'd0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            decim_q      <= decim_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            done_q       <= done_d;
            rd_ok_q      <= ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (sample_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; the range flag masks it instead.
    assign rd_data      = rd_ok_q ? ram_rdata : '0;
    assign capture_done = done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Directed bench for waveform_capture: DECIM=1 and DECIM=4 instances.
module tb_waveform_capture;
    import scope_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [11:0] sd_a = '0, lvl_a = 12'd2048, rd_a;
    logic        sv_a = 1'b0, rearm_a = 1'b0, cd_a, at_a;
    logic [9:0]  ra_a = '0;
    logic [1:0]  st_a;

    logic [11:0] sd_b = '0, lvl_b = 12'd2048, rd_b;
    logic        sv_b = 1'b0, rearm_b = 1'b0, cd_b, at_b;
    logic [9:0]  ra_b = '0;
    logic [1:0]  st_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    waveform_capture #(.DECIM(1), .AUTO_TIMEOUT(1000)) dut_a (
        .clock(clk), .reset(rst), .sample_data(sd_a),
        .sample_valid(sv_a), .trigger_level(lvl_a), .rearm(rearm_a),
        .rd_addr(ra_a), .rd_data(rd_a), .capture_done(cd_a),
        .auto_trig(at_a), .state_dbg(st_a)
    );

    waveform_capture #(.DECIM(4)) dut_b (
        .clock(clk), .reset(rst), .sample_data(sd_b),
        .sample_valid(sv_b), .trigger_level(lvl_b), .rearm(rearm_b),
        .rd_addr(ra_b), .rd_data(rd_b), .capture_done(cd_b),
        .auto_trig(at_b), .state_dbg(st_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit sel_b;
        int addr;
        int exp;
    } rd_vec_t;

    rd_vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b0, 0, 2048};
        tbl[1]  = '{1'b0, 1, 2064};
        tbl[2]  = '{1'b0, 127, 4080};
        tbl[3]  = '{1'b0, 128, 0};
        tbl[4]  = '{1'b0, 129, 16};
        tbl[5]  = '{1'b0, 300, 2752};
        tbl[6]  = '{1'b0, 639, 4080};
        tbl[7]  = '{1'b0, 640, 0};
        tbl[8]  = '{1'b0, 1023, 0};
        tbl[9]  = '{1'b1, 0, 4095};
        tbl[10] = '{1'b1, 1, 0};
        tbl[11] = '{1'b1, 638, 4095};
        tbl[12] = '{1'b1, 639, 0};
        tbl[13] = '{1'b1, 700, 0};

        repeat (3) @(negedge clk);
        chk("reset_state", int'(st_a), 0);
        chk("reset_done", int'(cd_a), 0);
        chk("reset_auto", int'(at_a), 0);
        chk("reset_rd", int'(rd_a), 0);
        rst = 1'b0;

        // Ramp, step 16: crossing at sample 128, 640th write at sample 767.
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (k == 128) chk("ramp_armed", int'(st_a), 0);
            if (k == 129) chk("ramp_capture", int'(st_a), 1);
            if (k == 767) chk("ramp_done_pre", int'(cd_a), 0);
            if (k == 768) begin
                chk("ramp_done_post", int'(cd_a), 1);
                chk("ramp_hold", int'(st_a), 2);
            end
            sd_a = 12'((k * 16) % 4096);
            sv_a = 1'b1;
        end
        @(negedge clk);
        sv_a = 1'b0;
        chk("ramp_auto", int'(at_a), 0);

        // Square 0/full-scale, 4 strobes per level, DECIM=4.
        for (int k = 0; k < 2600; k++) begin
            @(negedge clk);
            if (k == 2563) chk("sq_done_pre", int'(cd_b), 0);
            if (k == 2564) chk("sq_done_post", int'(cd_b), 1);
            sd_b = ((k / 4) % 2 == 1) ? ADC_FULL_SCALE : 12'd0;
            sv_b = 1'b1;
        end
        @(negedge clk);
        sv_b = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (tbl[i].sel_b) ra_b = 10'(tbl[i].addr);
            else ra_a = 10'(tbl[i].addr);
            @(negedge clk);
            chk($sformatf("rd_%s_%0d", tbl[i].sel_b ? "b" : "a",
                          tbl[i].addr),
                tbl[i].sel_b ? int'(rd_b) : int'(rd_a), tbl[i].exp);
        end

        // Rearm in HOLD; the sample in the rearm cycle is dropped.
        @(negedge clk);
        rearm_a = 1'b1;
        sd_a = 12'd3000;
        sv_a = 1'b1;
        @(negedge clk);
        rearm_a = 1'b0;
        chk("rearm_done_clr", int'(cd_a), 0);
        chk("rearm_state", int'(st_a), 0);

        // Above level with no rising crossing must not trigger.
        repeat (700) @(negedge clk);
        chk("const_state", int'(st_a), 0);
        chk("const_done", int'(cd_a), 0);

        sd_a = 12'd100;
        @(negedge clk);
        sd_a = 12'd2100;
        @(negedge clk);
        sv_a = 1'b0;
        chk("fresh_trig", int'(st_a), 1);
        chk("fresh_auto", int'(at_a), 0);

        rearm_a = 1'b1;
        @(negedge clk);
        rearm_a = 1'b0;
        chk("rearm_in_capture", int'(st_a), 1);

        sd_a = 12'd500;
        sv_a = 1'b1;
        repeat (298) @(negedge clk);
        sv_a = 1'b0;
        chk("partial_state", int'(st_a), 1);

        ra_a = 10'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_state", int'(st_a), 0);
        chk("rst_mid_done", int'(cd_a), 0);
        chk("rst_mid_rd", int'(rd_a), 0);
        chk("rst_mid_auto", int'(at_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ram_kept_0", int'(rd_a), 2100);
        ra_a = 10'd5;
        @(negedge clk);
        chk("ram_kept_5", int'(rd_a), 500);

        sd_a = 12'd3000;
        sv_a = 1'b1;
        repeat (50) @(negedge clk);
        sv_a = 1'b0;
        chk("post_rst_state", int'(st_a), 0);
        chk("post_rst_done", int'(cd_a), 0);

`ifdef AUTO_TRIGGER_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sd_a = 12'd100;
        sv_a = 1'b1;
        for (int k = 0; k < 1030; k++) begin
            @(negedge clk);
            if (k == 990) chk("auto_wait", int'(st_a), 0);
            if (k == 1020) begin
                chk("auto_state", int'(st_a), 1);
                chk("auto_flag", int'(at_a), 1);
            end
        end
        sv_a = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/waveform_capture.md
# waveform_capture

Triggered single-shot sample buffer between the ADC serial-to-parallel stage and the VGA renderer. It takes 12-bit conversions from the ADC, optionally decimates them, and waits for a rising crossing of a programmable trigger level. It then records one screen-width of samples into on-chip RAM and holds them for the VGA stage to read out by column. The VGA stage re-arms the block once per frame.

## Interface
- DATA_W, 12, sample width
- DEPTH, 640, samples per capture (one per VGA column)
- ADDR_W, 10, RAM address width; 2**ADDR_W >= DEPTH
- DECIM, 1, keep every DECIM-th valid sample (1..255)
- AUTO_TIMEOUT, 50_000_000, clock cycles in ARMED before forced trigger (AUTO_TRIGGER_EN only)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_data  in  DATA_W  ADC parallel sample
- sample_valid  in  1  one-cycle strobe, new sample on sample_data
- trigger_level  in  DATA_W  unsigned trigger threshold
- rearm  in  1  one-cycle strobe from VGA, start next capture
- rd_addr  in  ADDR_W  VGA read column
- rd_data  out  DATA_W  sample at rd_addr, registered
- capture_done  out  1  buffer holds a complete capture
- auto_trig  out  1  last capture was forced by timeout
- state_dbg  out  2  current state encoding

## Operation
- Accepted sample: a sample_valid pulse where decim_cnt == DECIM-1. decim_cnt then wraps to 0; otherwise it increments. decim_cnt clears on entry to ARMED.
- States: ARMED=0, CAPTURE=1, HOLD=2. Encoding 3 is unused and recovers to ARMED.
- ARMED: on each accepted sample, load prev into the register and set prev_valid.
  - Trigger when prev_valid && prev < trigger_level && sample_data >= trigger_level (unsigned compare).
  - On trigger, write the sample to address 0, set wr_addr=1, go to CAPTURE.
- CAPTURE: each accepted sample writes to wr_addr, then wr_addr increments. The write to DEPTH-1 moves the block to HOLD.
- HOLD: capture_done=1. Samples are ignored. rearm moves the block to ARMED and clears capture_done, prev_valid and wr_addr.
- rearm outside HOLD is ignored.
- Reads are allowed in any state. During CAPTURE, partially overwritten data is acceptable. rd_addr >= DEPTH returns 0.
- Reset mid-capture aborts the capture. RAM contents are not cleared.

## Timing
- Reset values: state ARMED, capture_done 0, auto_trig 0, rd_data 0, wr_addr 0, decim_cnt 0, prev_valid 0, state_dbg 0.
- Trigger detection and RAM write happen at the same clock edge that the accepted sample is registered.
- capture_done rises in the cycle after the DEPTH-th write edge, and falls in the cycle after rearm is sampled.
- rd_data latency: 1 cycle from rd_addr.
- The minimum rearm-to-trigger time is two accepted samples, because prev must be refilled first.
- sample_valid arriving in the same cycle as the transition into HOLD is the DEPTH-th write and is not lost. sample_valid in the same cycle as rearm is dropped.

## Configuration
- AUTO_TRIGGER_EN defined:
  - A timeout counter runs in ARMED and clears on entering ARMED.
  - When it reaches AUTO_TIMEOUT, the next accepted sample triggers regardless of level, and auto_trig is set.
  - auto_trig clears on a level trigger.
- AUTO_TRIGGER_EN undefined: no timeout counter is built, and auto_trig is tied to 0.

## Structure
- Shared package scope_pkg holds:
  - state enum (ARMED/CAPTURE/HOLD)
  - DATA_W and DEPTH defaults
  - ADC full-scale constant 12'hFFF
- Sub-module capture_ram is simple dual-port: one write port and one registered read port, inferred block RAM.

## Test plan
- Ramp 0..4095 step 16, DECIM=1, level 2048 -> RAM[0]=2048, RAM[639]=(2048+639*16) mod 4096, capture_done 1 cycle after the 640th write.
- Constant 3000 with level 2048 -> no trigger (no rising crossing), capture_done stays 0, state_dbg=0.
- DECIM=4 square wave 0/4095 -> exactly 640 writes spanning 2560 valid strobes, RAM[0]=4095.
- rearm during CAPTURE -> ignored; rearm in HOLD -> capture_done=0 next cycle; the next capture requires a fresh crossing.
- reset asserted at write 300 -> all outputs at reset values immediately, state ARMED, capture_done 0 until a new complete capture.
- AUTO_TRIGGER_EN, AUTO_TIMEOUT=1000, flat input 100 -> capture starts at the first accepted sample after 1000 cycles, auto_trig=1.
